keypad_entry_controller: RTL

KEYPAD_ENTRY_CONTROLLER -- requirements
Module: keypad_entry_controller

---
 rtl/keypad_entry_controller.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/keypad_entry_controller.sv
// Keypad entry controller.
// Takes the key-held flag and key code from a keypad encoder, synchronizes
// and debounces the flag, accepts one key per press, and assembles a
// four-digit BCD code. Clear (*), enter (#), overflow, short-enter and
// idle-timeout handling are included. All outputs are registered.
module keypad_entry_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dav,
    input  logic [3:0]  d,
    output logic [15:0] code,
    output logic        code_valid,
    output logic [2:0]  digit_count,
    output logic        key_pulse,
    output logic        err,
    output logic        timeout
);

    // Counter widths are derived from the parameters, with a minimum of
    // one bit so that a parameter value of 1 still elaborates.
    localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES  > 1) ? $clog2(TIMEOUT_CYCLES)  : 1;

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;
    localparam logic [2:0] FULL_CNT  = 3'd4;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        PRESS_DEB   = 3'd1,
        ACCEPT      = 3'd2,
        HELD        = 3'd3,
        RELEASE_DEB = 3'd4
    } state_t;

    // Key classification: codes 0-9 are digits.
    function automatic logic is_digit(input logic [3:0] key);
        is_digit = (key <= 4'd9);
    endfunction

    // Shift a new digit into the least significant nibble of the buffer.
    function automatic logic [15:0] shift_in(input logic [15:0] buf_val,
                                             input logic [3:0]  digit);
        shift_in = {buf_val[11:0], digit};
    endfunction

    logic             sync1_r;
    logic             davs_r;
    state_t           state_r;
    state_t           state_next_s;
    logic [DEB_W-1:0] deb_cnt_r;
    logic [DEB_W-1:0] deb_cnt_next_s;
    logic             accept_s;
    logic [TO_W-1:0]  idle_cnt_r;
    logic [15:0]      code_r;
    logic [2:0]       digit_count_r;
    logic             code_valid_r;
    logic             key_pulse_r;
    logic             err_r;
    logic             timeout_r;
    logic             clear_pending_r;

    // Two-flop synchronizer for the asynchronous key-held flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            davs_r  <= 1'b0;
        end else begin
            sync1_r <= dav;
            davs_r  <= sync1_r;
        end
    end

    // Press/release FSM state and debounce counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            deb_cnt_r <= {DEB_W{1'b0}};
        end else begin
            state_r   <= state_next_s;
            deb_cnt_r <= deb_cnt_next_s;
        end
    end

    // Next-state logic: debounce press, accept once, debounce release.
    always_comb begin
        state_next_s   = state_r;
        deb_cnt_next_s = deb_cnt_r;
        accept_s       = 1'b0;
        case (state_r)
            IDLE: begin
                deb_cnt_next_s = {DEB_W{1'b0}};
                if (davs_r) begin
                    state_next_s = PRESS_DEB;
                end else begin
                    state_next_s = IDLE;
                end
            end
            PRESS_DEB: begin
                if (!davs_r) begin
                    state_next_s   = IDLE;
                    deb_cnt_next_s = {DEB_W{1'b0}};
                end else if (deb_cnt_r == DEB_LAST) begin
                    state_next_s   = ACCEPT;
                    deb_cnt_next_s = {DEB_W{1'b0}};
                end else begin
                    deb_cnt_next_s = deb_cnt_r + DEB_W'(1);
                end
            end
            ACCEPT: begin
                accept_s       = 1'b1;
                state_next_s   = HELD;
                deb_cnt_next_s = {DEB_W{1'b0}};
            end
            HELD: begin
                deb_cnt_next_s = {DEB_W{1'b0}};
                if (!davs_r) begin
                    state_next_s = RELEASE_DEB;
                end else begin
                    state_next_s = HELD;
                end
            end
            RELEASE_DEB: begin
                if (davs_r) begin
                    state_next_s   = HELD;
                    deb_cnt_next_s = {DEB_W{1'b0}};
                end else if (deb_cnt_r == DEB_LAST) begin
                    state_next_s   = IDLE;
                    deb_cnt_next_s = {DEB_W{1'b0}};
                end else begin
                    deb_cnt_next_s = deb_cnt_r + DEB_W'(1);
                end
            end
            default: begin
                state_next_s   = IDLE;
                deb_cnt_next_s = {DEB_W{1'b0}};
            end
        endcase
    end

    // Entry buffer, idle timer and status pulses. A key action always has
    // priority over the idle timeout, so code_valid/err and timeout can
    // never coincide. A completed code is held for the code_valid cycle
    // and cleared on the following one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            code_r          <= 16'h0000;
            digit_count_r   <= 3'd0;
            code_valid_r    <= 1'b0;
            key_pulse_r     <= 1'b0;
            err_r           <= 1'b0;
            timeout_r       <= 1'b0;
            idle_cnt_r      <= {TO_W{1'b0}};
            clear_pending_r <= 1'b0;
        end else begin
            key_pulse_r  <= accept_s;
            code_valid_r <= 1'b0;
            err_r        <= 1'b0;
            timeout_r    <= 1'b0;
            if (clear_pending_r) begin
                code_r          <= 16'h0000;
                digit_count_r   <= 3'd0;
                idle_cnt_r      <= {TO_W{1'b0}};
                clear_pending_r <= 1'b0;
            end else if (accept_s) begin
                idle_cnt_r <= {TO_W{1'b0}};
                if (is_digit(d)) begin
                    if (digit_count_r != FULL_CNT) begin
                        code_r        <= shift_in(code_r, d);
                        digit_count_r <= digit_count_r + 3'd1;
                    end else begin
                        err_r <= 1'b1;
                    end
                end else if (d == KEY_CLEAR) begin
                    code_r        <= 16'h0000;
                    digit_count_r <= 3'd0;
                end else if (d == KEY_ENTER) begin
                    if (digit_count_r == FULL_CNT) begin
                        code_valid_r    <= 1'b1;
                        clear_pending_r <= 1'b1;
                    end else begin
                        err_r         <= 1'b1;
                        code_r        <= 16'h0000;
                        digit_count_r <= 3'd0;
                    end
                end else begin
                    // Codes C-F: only the key pulse is produced.
                    code_r <= code_r;
                end
            end else if (digit_count_r == 3'd0) begin
                idle_cnt_r <= {TO_W{1'b0}};
            end else if (idle_cnt_r == TO_LAST) begin
                timeout_r     <= 1'b1;
                code_r        <= 16'h0000;
                digit_count_r <= 3'd0;
                idle_cnt_r    <= {TO_W{1'b0}};
            end else begin
                idle_cnt_r <= idle_cnt_r + TO_W'(1);
            end
        end
    end

    assign code        = code_r;
    assign digit_count = digit_count_r;
    assign code_valid  = code_valid_r;
    assign key_pulse   = key_pulse_r;
    assign err         = err_r;
    assign timeout     = timeout_r;

endmodule
